// File: rtl/mintz80_pkg.sv
// Shared constants for the MintZ80 RTC interface: I/O port numbers, status bit
// positions and the serial engine state encoding.
package mintz80_pkg;

    localparam logic [7:0] IO_RTC_DATA = 8'hD0;
    localparam logic [7:0] IO_RTC_CTRL = 8'hD2;

    localparam int BUSY = 7;
    localparam int OVR  = 6;
    localparam int CE   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } rtc_state_e;

endpackage

// File: rtl/mintz80_busync.sv
// Two-flop synchronizer for an active-low Z80 strobe, followed by a one-clock
// pulse on the synchronized assertion (falling) edge.
module mintz80_busync
    import mintz80_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sig_n_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= sig_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = prev_q & ~sync_q;

endmodule

// File: rtl/mintz80_rtcif.sv
// MintZ80 RTC interface: ports $D0 (data) / $D2 (control/status) to a 3-wire
// DS1302-style RTC. Define MINTZ80_RTCIF_WAIT_EN to stall $D0 reads on /WAIT.
module mintz80_rtcif
    import mintz80_pkg::*;
#(
    parameter int CLKDIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd,
    input  logic       wr,
    input  logic       iorq,
    input  logic [7:0] a07,
    inout  wire  [7:0] data,
    output logic       rtc_ce,
    output logic       rtc_sclk,
    output logic       rtc_io_out,
    output logic       rtc_io_oe,
    input  logic       rtc_io_in,
    output logic       wait_n
);

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    logic       sel_d0;
    logic       sel_d2;
    logic       wr_pulse;
    logic       rd_pulse;
    logic       wp_d0;
    logic       wp_d2;
    logic       rd_d0;
    logic       rd_d2;
    logic       idle;
    logic       busy;
    logic       start_tx;
    logic       start_rx;
    logic       reject;
    logic       div_end;
    logic [7:0] status;

    rtc_state_e state_q, state_d;
    logic [7:0] divcnt_q, divcnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       rx_mode_q, rx_mode_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_buf_q, rx_buf_d;
    logic       ce_q, ce_d;
    logic       ovr_q, ovr_d;
    logic       sclk_q, sclk_d;
    logic       io_out_q, io_out_d;
    logic       io_oe_q, io_oe_d;

    assign sel_d0 = !iorq && (a07 == IO_RTC_DATA);
    assign sel_d2 = !iorq && (a07 == IO_RTC_CTRL);

    mintz80_busync u_wr_sync (
        .clk     (clk),
        .reset   (reset),
        .sig_n_i (wr),
        .pulse_o (wr_pulse)
    );

    mintz80_busync u_rd_sync (
        .clk     (clk),
        .reset   (reset),
        .sig_n_i (rd),
        .pulse_o (rd_pulse)
    );

    assign wp_d0 = wr_pulse && sel_d0;
    assign wp_d2 = wr_pulse && sel_d2;
    assign idle  = (state_q == IDLE);
    assign busy  = !idle;

    // A $D2 write that sets CE and requests RX in one go is honoured, so the
    // start test uses the CE value being written rather than the old one.
    assign start_tx = wp_d0 && idle && ce_q;
    assign start_rx = wp_d2 && data[1] && idle && data[CE];
    assign reject   = (wp_d0 && !(idle && ce_q))
                   || (wp_d2 && data[1] && !(idle && data[CE]));

    always_comb begin
        ce_d = ce_q;
        if (wp_d2) begin
            ce_d = data[CE];
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (reject) begin
            ovr_d = 1'b1;
        end else if (rd_pulse && sel_d2) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            divcnt_q  <= '0;
            bitcnt_q  <= '0;
            rx_mode_q <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_buf_q  <= '0;
            ce_q      <= 1'b0;
            ovr_q     <= 1'b0;
            sclk_q    <= 1'b0;
            io_out_q  <= 1'b0;
            io_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            divcnt_q  <= divcnt_d;
            bitcnt_q  <= bitcnt_d;
            rx_mode_q <= rx_mode_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_buf_q  <= rx_buf_d;
            ce_q      <= ce_d;
            ovr_q     <= ovr_d;
            sclk_q    <= sclk_d;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        divcnt_d  = divcnt_q;
        bitcnt_d  = bitcnt_q;
        rx_mode_d = rx_mode_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_buf_d  = rx_buf_q;
        div_end   = (divcnt_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                if (start_tx || start_rx) begin
                    state_d   = LOW;
                    divcnt_d  = '0;
                    bitcnt_d  = '0;
                    rx_mode_d = start_rx;
                    if (start_tx) begin
                        tx_sr_d = data;
                    end
                end
            end
            LOW: begin
                if (div_end) begin
                    state_d  = HIGH;
                    divcnt_d = '0;
                    if (rx_mode_q) begin
                        rx_sr_d = {rtc_io_in, rx_sr_q[7:1]};
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (div_end) begin
                    divcnt_d = '0;
                    if (!rx_mode_q) begin
                        tx_sr_d = {1'b0, tx_sr_q[7:1]};
                    end
                    if (bitcnt_q == 3'd7) begin
                        state_d = IDLE;
                        if (rx_mode_q) begin
                            rx_buf_d = rx_sr_q;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        state_d  = LOW;
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Dropping CE mid-byte abandons the transfer; rx_buf keeps its old value.
        if (busy && !ce_d) begin
            state_d = IDLE;
        end
    end

    // Pins are registered from the next state so SCLK and IO never glitch.
    always_comb begin
        sclk_d   = (state_d == HIGH);
        io_oe_d  = (state_d != IDLE) && !rx_mode_d;
        io_out_d = io_oe_d ? tx_sr_d[0] : 1'b0;
    end

    assign rtc_ce     = ce_q;
    assign rtc_sclk   = sclk_q;
    assign rtc_io_out = io_out_q;
    assign rtc_io_oe  = io_oe_q;

    always_comb begin
        status       = '0;
        status[BUSY] = busy;
        status[OVR]  = ovr_q;
        status[CE]   = ce_q;
    end

    assign rd_d0 = !rd && sel_d0;
    assign rd_d2 = !rd && sel_d2;
    assign data  = rd_d0 ? rx_buf_q : (rd_d2 ? status : 8'bz);

`ifdef MINTZ80_RTCIF_WAIT_EN
    assign wait_n = !(rd_d0 && busy);
`else
    assign wait_n = 1'b1;
`endif

endmodule
